// File: rtl/row_cmd_loader.sv
// row_cmd_loader: parses 'L',row,pixels byte records into framebuffer writes with timeout and discard recovery
module row_cmd_loader #(
  parameter int PIXELS_PER_ROW = 32,
  parameter int COL_BITS = 5,
  parameter int ROW_BITS = 5,
  parameter logic [7:0] HEADER_BYTE = 8'h4C,
  parameter int TIMEOUT_TICKS = 2000,
  parameter int TIMEOUT_WIDTH = 11
) (
  input  logic                         clk_in,
  input  logic                         reset,
  input  logic [7:0]                   rx_data,
  input  logic                         rx_valid,
  output logic                         wr_en,
  output logic [ROW_BITS+COL_BITS-1:0] wr_addr,
  output logic [15:0]                  wr_data,
  output logic                         row_done,
  output logic [ROW_BITS-1:0]          row_done_index,
  output logic                         err,
  output logic                         busy
);
  localparam int REM_W = $clog2(2*PIXELS_PER_ROW+1);
  typedef enum logic [2:0] {IDLE, ROW, PIX_HI, PIX_LO, DISCARD} state_t;
  state_t state, state_n;
  logic [ROW_BITS-1:0] row;
  logic [COL_BITS-1:0] col;
  logic [7:0] hi;
  logic [REM_W-1:0] remaining;
  logic [TIMEOUT_WIDTH-1:0] tcnt;
  logic timeout, row_ok, last;
  always_comb begin
    timeout = state != IDLE && !rx_valid && tcnt == TIMEOUT_WIDTH'(TIMEOUT_TICKS-1);
    row_ok = (rx_data >> ROW_BITS) == 8'd0;
    last = col == COL_BITS'(PIXELS_PER_ROW-1);
    busy = state != IDLE;
    state_n = state;
    if (timeout)
      state_n = IDLE;
    else if (rx_valid)
      case (state)
        IDLE:    state_n = rx_data == HEADER_BYTE ? ROW : IDLE;
        ROW:     state_n = row_ok ? PIX_HI : DISCARD;
        PIX_HI:  state_n = PIX_LO;
        PIX_LO:  state_n = last ? IDLE : PIX_HI;
        DISCARD: state_n = remaining == REM_W'(1) ? IDLE : DISCARD;
        default: state_n = IDLE;
      endcase
  end
  always_ff @(posedge clk_in or posedge reset)
    if (reset)
      state <= IDLE;
    else
      state <= state_n;
  // the byte beats the timeout: a strobe on the would-be expiry cycle clears the count
  always_ff @(posedge clk_in or posedge reset)
    if (reset) begin
      row <= '0;
      col <= '0;
      hi <= '0;
      remaining <= '0;
      tcnt <= '0;
      wr_en <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      row_done <= 1'b0;
      row_done_index <= '0;
      err <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      row_done <= 1'b0;
      err <= timeout;
      tcnt <= (state == IDLE || rx_valid || timeout) ? '0 : tcnt + 1'b1;
      if (rx_valid)
        case (state)
          ROW: begin
            if (row_ok) row <= rx_data[ROW_BITS-1:0];
            col <= '0;
            remaining <= REM_W'(2*PIXELS_PER_ROW);
            err <= !row_ok;
          end
          PIX_HI: hi <= rx_data;
          PIX_LO: begin
            wr_en <= 1'b1;
            wr_addr <= {row, col};
            wr_data <= {hi, rx_data};
            col <= col + 1'b1;
            if (last) begin
              row_done <= 1'b1;
              row_done_index <= row;
            end
          end
          DISCARD: remaining <= remaining - 1'b1;
          default: ;
        endcase
    end
endmodule

// File: tb/tb_row_cmd_loader.sv
// tb_row_cmd_loader: directed vectors and record sequences for row_cmd_loader
module tb_row_cmd_loader;
  logic clk_in = 1'b0, reset = 1'b1, rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic wr_en, row_done, err, busy;
  logic [9:0] wr_addr;
  logic [15:0] wr_data;
  logic [4:0] row_done_index;
  int nvec = 0, nmis = 0;
  int nwr = 0, ndone = 0, nerr = 0;
  logic [9:0] wl_a[1024];
  logic [15:0] wl_d[1024];
  logic [4:0] dl_idx[64];
  int dl_wr[64];
  int w0, d0, e0;

  row_cmd_loader dut (
    .clk_in(clk_in), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .row_done(row_done),
    .row_done_index(row_done_index), .err(err), .busy(busy)
  );

  always #5 clk_in = ~clk_in;

  always @(negedge clk_in)
    if (!reset) begin
      if (wr_en) begin
        wl_a[nwr % 1024] = wr_addr;
        wl_d[nwr % 1024] = wr_data;
        nwr++;
      end
      if (row_done) begin
        dl_idx[ndone % 64] = row_done_index;
        dl_wr[ndone % 64] = nwr;
        ndone++;
      end
      if (err) nerr++;
    end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected finish earlier");
    $fatal(1);
  end

  typedef struct {
    logic v; logic [7:0] d;
    logic we; logic [9:0] a; logic [15:0] wd; logic dn; logic er; logic bz;
  } vec_t;
  vec_t tbl[10];

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    nvec++;
    if (a !== e) begin
      nmis++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask

  function automatic logic [15:0] pix(input int r, input int c);
    return {8'(c) ^ 8'hA5, 8'(r)};
  endfunction

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data = b;
    @(negedge clk_in);
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic send_row(input int r, input int c0, input int n);
    logic [15:0] p;
    for (int c = c0; c < c0 + n; c++) begin
      p = pix(r, c);
      send(p[15:8]);
      send(p[7:0]);
    end
  endtask

  task automatic check_writes(input int base, input int r, input int c0, input int n);
    for (int i = 0; i < n; i++) begin
      chk("wr_addr", 32'(wl_a[(base + i) % 1024]), 32'({5'(r), 5'(c0 + i)}));
      chk("wr_data", 32'(wl_d[(base + i) % 1024]), 32'(pix(r, c0 + i)));
    end
  endtask

  initial begin
    tbl[0] = '{1'b1, 8'h00, 1'b0, 10'h000, 16'h0000, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 8'hFF, 1'b0, 10'h000, 16'h0000, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 8'h4B, 1'b0, 10'h000, 16'h0000, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 8'h00, 1'b0, 10'h000, 16'h0000, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 8'h4C, 1'b0, 10'h000, 16'h0000, 1'b0, 1'b0, 1'b1};
    tbl[5] = '{1'b1, 8'h03, 1'b0, 10'h000, 16'h0000, 1'b0, 1'b0, 1'b1};
    tbl[6] = '{1'b1, 8'h12, 1'b0, 10'h000, 16'h0000, 1'b0, 1'b0, 1'b1};
    tbl[7] = '{1'b0, 8'h00, 1'b0, 10'h000, 16'h0000, 1'b0, 1'b0, 1'b1};
    tbl[8] = '{1'b1, 8'h34, 1'b1, 10'h060, 16'h1234, 1'b0, 1'b0, 1'b1};
    tbl[9] = '{1'b0, 8'h00, 1'b0, 10'h000, 16'h0000, 1'b0, 1'b0, 1'b1};

    idle(2);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_row_done", row_done, 0);
    chk("rst_done_idx", row_done_index, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b0;
    idle(1);

    // noise bytes then start of row 3 record
    w0 = nwr; d0 = ndone; e0 = nerr;
    for (int i = 0; i < 10; i++) begin
      rx_valid = tbl[i].v;
      rx_data = tbl[i].d;
      @(negedge clk_in);
      chk($sformatf("tbl%0d_wr_en", i), wr_en, tbl[i].we);
      chk($sformatf("tbl%0d_row_done", i), row_done, tbl[i].dn);
      chk($sformatf("tbl%0d_err", i), err, tbl[i].er);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].bz);
      if (tbl[i].we) begin
        chk($sformatf("tbl%0d_wr_addr", i), wr_addr, tbl[i].a);
        chk($sformatf("tbl%0d_wr_data", i), wr_data, tbl[i].wd);
      end
    end
    rx_valid = 1'b0;
    for (int i = 0; i < 62; i++) send(8'h00);
    idle(2);
    chk("t1_writes", nwr - w0, 32);
    chk("t1_first_addr", wl_a[w0 % 1024], 10'h060);
    chk("t1_first_data", wl_d[w0 % 1024], 16'h1234);
    chk("t1_last_addr", wl_a[(w0 + 31) % 1024], {5'd3, 5'd31});
    chk("t1_last_data", wl_d[(w0 + 31) % 1024], 16'h0000);
    chk("t1_dones", ndone - d0, 1);
    chk("t1_done_idx", dl_idx[d0 % 64], 5'd3);
    chk("t1_done_on_last_wr", dl_wr[d0 % 64], w0 + 32);
    chk("t1_errs", nerr - e0, 0);
    chk("t1_busy", busy, 0);

    // back-to-back records with zero gap
    w0 = nwr; d0 = ndone; e0 = nerr;
    send(8'h4C); send(8'h09); send_row(9, 0, 32);
    send(8'h4C); send(8'h19); send_row(25, 0, 32);
    idle(2);
    chk("t2_writes", nwr - w0, 64);
    check_writes(w0, 9, 0, 32);
    check_writes(w0 + 32, 25, 0, 32);
    chk("t2_dones", ndone - d0, 2);
    chk("t2_done_idx0", dl_idx[d0 % 64], 5'd9);
    chk("t2_done_idx1", dl_idx[(d0 + 1) % 64], 5'd25);
    chk("t2_errs", nerr - e0, 0);

    // out-of-range row: discard 64 bytes, embedded header is payload
    w0 = nwr; d0 = ndone; e0 = nerr;
    send(8'h4C); send(8'h20);
    chk("t3_err_pulse", err, 1);
    for (int i = 0; i < 64; i++) begin
      send(i == 10 ? 8'h4C : i == 11 ? 8'h05 : 8'(i));
      if (i == 62) chk("t3_busy_63", busy, 1);
      if (i == 63) chk("t3_busy_64", busy, 0);
    end
    idle(2);
    chk("t3_errs", nerr - e0, 1);
    chk("t3_writes", nwr - w0, 0);
    chk("t3_dones", ndone - d0, 0);
    w0 = nwr; d0 = ndone;
    send(8'h4C); send(8'h01); send_row(1, 0, 32);
    idle(2);
    chk("t3b_writes", nwr - w0, 32);
    check_writes(w0, 1, 0, 32);
    chk("t3b_done_idx", dl_idx[d0 % 64], 5'd1);

    // timeout after a high byte
    w0 = nwr; e0 = nerr;
    send(8'h4C); send(8'h02); send(8'hAB);
    idle(1999);
    chk("t4_err_early", err, 0);
    chk("t4_busy_early", busy, 1);
    idle(1);
    chk("t4_err", err, 1);
    chk("t4_busy", busy, 0);
    idle(2);
    chk("t4_errs", nerr - e0, 1);
    chk("t4_writes", nwr - w0, 0);
    // byte on the would-be expiry cycle wins
    w0 = nwr; d0 = ndone; e0 = nerr;
    send(8'h4C); send(8'h02); send(8'hAB);
    idle(1999);
    send(8'hCD);
    chk("t4b_wr_en", wr_en, 1);
    chk("t4b_wr_addr", wr_addr, {5'd2, 5'd0});
    chk("t4b_wr_data", wr_data, 16'hABCD);
    chk("t4b_err", err, 0);
    chk("t4b_busy", busy, 1);
    send_row(2, 1, 31);
    idle(2);
    chk("t4b_writes", nwr - w0, 32);
    check_writes(w0 + 1, 2, 1, 31);
    chk("t4b_done_idx", dl_idx[d0 % 64], 5'd2);
    chk("t4b_errs", nerr - e0, 0);

    // reset mid-record
    e0 = nerr;
    send(8'h4C); send(8'h07); send_row(7, 0, 10);
    reset = 1'b1;
    #1;
    chk("t5_wr_en", wr_en, 0);
    chk("t5_wr_addr", wr_addr, 0);
    chk("t5_wr_data", wr_data, 0);
    chk("t5_row_done", row_done, 0);
    chk("t5_done_idx", row_done_index, 0);
    chk("t5_err", err, 0);
    chk("t5_busy", busy, 0);
    @(negedge clk_in);
    reset = 1'b0;
    idle(1);
    w0 = nwr; d0 = ndone;
    send(8'h4C); send(8'h07); send_row(7, 0, 32);
    idle(2);
    chk("t5_writes", nwr - w0, 32);
    check_writes(w0, 7, 0, 32);
    chk("t5_dones", ndone - d0, 1);
    chk("t5_done_idx_end", dl_idx[d0 % 64], 5'd7);
    chk("t5_errs", nerr - e0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
